// File: rtl/lcd_result_writer.sv
// lcd_result_writer: drives an HD44780 in 8-bit mode with a reaction-time result
// accepted over a four-phase LCDUpdate/LCDAck handshake.
module lcd_result_writer #(
    parameter int INIT_WAIT = 20,
    parameter int CMD_WAIT  = 1,
    parameter int CLR_WAIT  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_lcd_update,
    input  logic [9:0] i_reaction_time,
    input  logic       i_cheat,
    input  logic       i_slow,
    output logic       o_lcd_ack,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_db,
    output logic       o_busy
);
    typedef enum logic [3:0] {INIT_DLY, INIT_CMD, IDLE, ACK, CONVERT, CLEAR, WRITE, STROBE, HOLD} state_t;
    localparam logic [31:0] INIT_SEQ = 32'h380C_0601;
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_idx;
    logic        r_init;
    logic [9:0]  r_rt;
    logic        r_cheat;
    logic        r_slow;
    logic [15:0] r_bcd;
    logic        r_ack;
    logic        r_rs;
    logic        r_e;
    logic [7:0]  r_db;
    logic [14:0] w_adj;
    logic [15:0] w_wait;
    logic        w_hold_done;
    logic [3:0]  w_len;
    logic [7:0]  w_d3;
    logic [7:0]  w_d2;
    logic [7:0]  w_d1;
    logic [7:0]  w_d0;
    logic [95:0] w_msg;
    logic [7:0]  w_char;
    logic [1:0]  w_nxt;
    logic [7:0]  w_init_next;
    // A 10-bit value never pushes the thousands digit past 1, so it needs no +3 adjust.
    for (genvar g = 0; g < 3; g++) begin : g_adj
        assign w_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ? r_bcd[g*4 +: 4] + 4'd3 : r_bcd[g*4 +: 4];
    end
    assign w_adj[14:12] = r_bcd[14:12];
    assign w_d3 = (r_bcd[15:12] == 4'd0) ? 8'h20 : {4'h3, r_bcd[15:12]};
    assign w_d2 = (r_bcd[15:8] == 8'd0) ? 8'h20 : {4'h3, r_bcd[11:8]};
    assign w_d1 = (r_bcd[15:4] == 12'd0) ? 8'h20 : {4'h3, r_bcd[7:4]};
    assign w_d0 = {4'h3, r_bcd[3:0]};
    assign w_len = r_cheat ? 4'd6 : r_slow ? 4'd8 : 4'd12;
    assign w_msg = r_cheat ? {"CHEAT!", 48'h0} : r_slow ? {"TOO SLOW", 32'h0} : {"TIME ", w_d3, w_d2, w_d1, w_d0, " MS"};
    assign w_char = w_msg[7'd95 - {r_idx, 3'b000} -: 8];
    assign w_nxt = r_idx[1:0] + 2'd1;
    assign w_init_next = INIT_SEQ[5'd31 - {w_nxt, 3'b000} -: 8];
    assign w_wait = (!r_rs && r_db == 8'h01) ? 16'(CLR_WAIT) : 16'(CMD_WAIT);
    assign w_hold_done = r_cnt + 16'd1 >= w_wait;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= INIT_DLY;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_init  <= 1'b1;
            r_rt    <= '0;
            r_cheat <= 1'b0;
            r_slow  <= 1'b0;
            r_bcd   <= '0;
            r_ack   <= 1'b0;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_db    <= '0;
        end else begin
            case (r_state)
                INIT_DLY: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == 16'(INIT_WAIT - 1)) begin
                        r_state <= INIT_CMD;
                        r_db    <= INIT_SEQ[31:24];
                        r_rs    <= 1'b0;
                        r_idx   <= '0;
                        r_init  <= 1'b1;
                    end
                end
                INIT_CMD, CLEAR, WRITE: begin
                    r_e     <= 1'b1;
                    r_state <= STROBE;
                end
                STROBE: begin
                    r_e     <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= HOLD;
                end
                // HOLD decides the next byte; r_idx counts bytes already issued.
                HOLD: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_hold_done) begin
                        if (r_init ? r_idx == 4'd3 : r_idx == w_len) begin
                            r_state <= IDLE;
                            r_init  <= 1'b0;
                        end else if (r_init) begin
                            r_idx   <= r_idx + 4'd1;
                            r_db    <= w_init_next;
                            r_state <= INIT_CMD;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_db    <= w_char;
                            r_rs    <= 1'b1;
                            r_state <= WRITE;
                        end
                    end
                end
                IDLE: if (i_lcd_update) begin
                    r_rt    <= i_reaction_time;
                    r_cheat <= i_cheat;
                    r_slow  <= i_slow;
                    r_ack   <= 1'b1;
                    r_state <= ACK;
                end
                ACK: if (!i_lcd_update) begin
                    r_ack   <= 1'b0;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= CONVERT;
                end
                CONVERT: begin
                    r_bcd <= {w_adj, r_rt[9]};
                    r_rt  <= {r_rt[8:0], 1'b0};
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == 16'd9) begin
                        r_state <= CLEAR;
                        r_db    <= 8'h01;
                        r_rs    <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                default: r_state <= INIT_DLY;
            endcase
        end
    end
    assign o_lcd_ack = r_ack;
    assign o_lcd_rs  = r_rs;
    assign o_lcd_rw  = 1'b0;
    assign o_lcd_e   = r_e;
    assign o_lcd_db  = r_db;
    assign o_busy    = r_state != IDLE;
endmodule
